// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared definitions for the Hamming(7,4) transmit and receive ends.
//   Both ends use the codeword bit map defined here:
//     [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3 (even parity)
//   Contents:
//     nibble_t / codeword_t : data and code widths
//     P1..D3                : bit positions inside a codeword
//     tx_state_t            : byte transmitter FSM states
//     hamming_encode4()     : 4-bit nibble -> 7-bit codeword
package hamming_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] codeword_t;

   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D0 = 2;
   localparam int P4 = 3;
   localparam int D1 = 4;
   localparam int D2 = 5;
   localparam int D3 = 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND_LO = 2'd1,
      ST_SEND_HI = 2'd2
   } tx_state_t;

   function automatic codeword_t hamming_encode4(input nibble_t d);
      codeword_t cw;
      cw[D0] = d[0];
      cw[D1] = d[1];
      cw[D2] = d[2];
      cw[D3] = d[3];
      cw[P1] = d[0] ^ d[1] ^ d[3];
      cw[P2] = d[0] ^ d[2] ^ d[3];
      cw[P4] = d[1] ^ d[2] ^ d[3];
      return cw;
   endfunction

endpackage

// File: rtl/hamming_encode_core.sv
// hamming_encode_core
//   Purely combinational Hamming(7,4) encoder built on the shared package
//   function, so transmitter and decoder cannot drift apart on the bit map.
//   Ports:
//     nib  in  4  data nibble
//     cw   out 7  encoded codeword
module hamming_encode_core
   import hamming_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] cw
);

   assign cw = hamming_encode4(nib);

endmodule

// File: rtl/hamming_byte_tx.sv
// hamming_byte_tx
//   Transmit end of the Hamming(7,4) link. Each accepted byte is sent as two
//   registered codewords, low nibble first, with optional single-bit error
//   injection on the low codeword to exercise the decoder's correction path.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     byte handshake, in_data[3:0] sent first
//     in_data[7:0]          byte to transmit
//     inject_en             sampled with the byte: corrupt its low codeword
//     inject_pos[2:0]       1..7 flips codeword bit pos-1, 0 = no flip
//     cw_valid/cw_ready     codeword handshake (cw_valid registered)
//     cw_data[6:0]          codeword (registered)
//     cw_count[CNT_W-1:0]   accepted codewords, wraps silently
module hamming_byte_tx
   import hamming_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int INJECT_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             inject_en,
   input  logic [2:0]       inject_pos,
   output logic             cw_valid,
   output logic [6:0]       cw_data,
   input  logic             cw_ready,
   output logic [CNT_W-1:0] cw_count
);

   tx_state_t        state_q,    state_d;
   logic [6:0]       cw_data_q,  cw_data_d;
   logic             cw_valid_q, cw_valid_d;
   logic [3:0]       hi_nib_q,   hi_nib_d;
   logic [CNT_W-1:0] cw_count_q, cw_count_d;

   logic [6:0] lo_cw;
   logic [6:0] hi_cw;
   logic [6:0] flip_mask;
   logic       load_byte;
   logic       cw_fire;

   // Low codeword is encoded straight from the incoming byte; the high one
   // from the held nibble so it is ready the cycle the low one is taken.
   hamming_encode_core u_enc_lo (
      .nib (in_data[3:0]),
      .cw  (lo_cw)
   );

   hamming_encode_core u_enc_hi (
      .nib (hi_nib_q),
      .cw  (hi_cw)
   );

   if (INJECT_EN != 0) begin : g_inject
      always_comb begin
         flip_mask = '0;
         if (inject_en && (inject_pos != 3'd0)) begin
            flip_mask = 7'd1 << (inject_pos - 3'd1);
         end
      end
   end else begin : g_no_inject
      logic unused_inject;
      assign unused_inject = ^{inject_en, inject_pos};
      assign flip_mask     = '0;
   end

   // Depends only on state and cw_ready, never on in_valid.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE:    in_ready = 1'b1;
         ST_SEND_LO: in_ready = 1'b0;
         ST_SEND_HI: in_ready = cw_ready;
         default:    in_ready = 1'b0;
      endcase
   end

   assign load_byte = in_valid & in_ready;
   assign cw_fire   = cw_valid_q & cw_ready;

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d    = state_q;
      cw_data_d  = cw_data_q;
      cw_valid_d = cw_valid_q;
      hi_nib_d   = hi_nib_q;
      cw_count_d = cw_fire ? cw_count_q + CNT_W'(1) : cw_count_q;

      case (state_q)
         ST_IDLE: begin
            cw_valid_d = 1'b0;
         end
         ST_SEND_LO: begin
            if (cw_ready) begin
               state_d   = ST_SEND_HI;
               cw_data_d = hi_cw;
            end
         end
         ST_SEND_HI: begin
            if (cw_ready && !in_valid) begin
               state_d    = ST_IDLE;
               cw_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            cw_valid_d = 1'b0;
         end
      endcase

      // A byte taken in IDLE or on the SEND_HI handshake goes out next cycle,
      // giving back-to-back codewords with no bubble.
      if (load_byte) begin
         state_d    = ST_SEND_LO;
         cw_valid_d = 1'b1;
         cw_data_d  = lo_cw ^ flip_mask;
         hi_nib_d   = in_data[7:4];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cw_data_q  <= '0;
         cw_valid_q <= 1'b0;
         hi_nib_q   <= '0;
         cw_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cw_data_q  <= cw_data_d;
         cw_valid_q <= cw_valid_d;
         hi_nib_q   <= hi_nib_d;
         cw_count_q <= cw_count_d;
      end
   end

   assign cw_valid = cw_valid_q;
   assign cw_data  = cw_data_q;
   assign cw_count = cw_count_q;

endmodule

// File: tb/tb_hamming_byte_tx.sv
// tb_hamming_byte_tx
//   Self-checking bench for hamming_byte_tx. Three instances share stimulus:
//   the default build, a 4-bit counter build and a build without injection
//   logic. A scoreboard queue of expected codewords, derived from the
//   position-XOR view of Hamming codes, predicts every output cycle.
module tb_hamming_byte_tx;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       inject_en;
   logic [2:0] inject_pos;
   logic       cw_ready;

   logic        in_ready,  c4_in_ready,  ni_in_ready;
   logic        cw_valid,  c4_cw_valid,  ni_cw_valid;
   logic [6:0]  cw_data,   c4_cw_data,   ni_cw_data;
   logic [15:0] cw_count,  ni_cw_count;
   logic [3:0]  c4_cw_count;

   hamming_byte_tx dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .inject_en(inject_en), .inject_pos(inject_pos),
      .cw_valid(cw_valid), .cw_data(cw_data), .cw_ready(cw_ready),
      .cw_count(cw_count)
   );

   hamming_byte_tx #(.CNT_W(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(c4_in_ready), .inject_en(inject_en), .inject_pos(inject_pos),
      .cw_valid(c4_cw_valid), .cw_data(c4_cw_data), .cw_ready(cw_ready),
      .cw_count(c4_cw_count)
   );

   hamming_byte_tx #(.INJECT_EN(0)) dut_ni (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ni_in_ready), .inject_en(inject_en), .inject_pos(inject_pos),
      .cw_valid(ni_cw_valid), .cw_data(ni_cw_data), .cw_ready(cw_ready),
      .cw_count(ni_cw_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] cw;     // expected on the injecting build
      logic [6:0] clean;  // expected on the non-injecting build
      logic [3:0] nib;
      logic       inj;
   } exp_t;

   exp_t       exp_q[$];
   logic [6:0] hs_log[$];
   logic [6:0] ni_log[$];
   logic [31:0] model_cnt;
   logic        hold_prev;
   logic [6:0]  prev_data;
   logic        last_accept;
   int          checks;
   int          errors;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Data sits at codeword positions 3,5,6,7 (1-based); parity bits at 1,2,4
   // are chosen so the XOR of the positions of all set bits is zero.
   function automatic logic [6:0] ref_encode(input logic [3:0] n);
      int         dpos[4];
      int         s;
      logic [7:1] w;
      dpos = '{3, 5, 6, 7};
      s = 0;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         if (n[i]) begin
            w[dpos[i]] = 1'b1;
            s = s ^ dpos[i];
         end
      end
      w[1] = (s & 1) != 0;
      w[2] = (s & 2) != 0;
      w[4] = (s & 4) != 0;
      return w[7:1];
   endfunction

   // Syndrome = XOR of positions of set bits; nonzero names the bad bit.
   function automatic logic [4:0] ref_decode(input logic [6:0] cw);
      int         s;
      logic [7:1] w;
      w = cw;
      s = 0;
      for (int k = 1; k <= 7; k++) begin
         if (w[k]) s = s ^ k;
      end
      if (s != 0) w[s] = ~w[s];
      return {s != 0, w[7], w[6], w[5], w[3]};
   endfunction

   // One clock: check outputs on the falling edge against the scoreboard,
   // then return 1 time unit after the next rising edge.
   task automatic cycle();
      exp_t       e;
      logic       exp_rdy;
      logic [4:0] dec;
      logic [6:0] raw;
      @(negedge clk);
      check("cw_valid", cw_valid, exp_q.size() != 0);
      check("ni_cw_valid", ni_cw_valid, exp_q.size() != 0);
      if (exp_q.size() == 0)      exp_rdy = 1'b1;
      else if (exp_q.size() == 2) exp_rdy = 1'b0;
      else                        exp_rdy = cw_ready;
      check("in_ready", in_ready, exp_rdy);
      check("cw_count", cw_count, model_cnt[15:0]);
      check("c4_cw_count", c4_cw_count, model_cnt[3:0]);
      if (hold_prev) check("cw_stable", cw_data, prev_data);
      hold_prev = cw_valid && !cw_ready;
      prev_data = cw_data;
      if (cw_valid && cw_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("cw_data", cw_data, e.cw);
         check("ni_cw_data", ni_cw_data, e.clean);
         dec = ref_decode(cw_data);
         check("decoded_nib", dec[3:0], e.nib);
         check("corrected", dec[4], e.inj);
         hs_log.push_back(cw_data);
         ni_log.push_back(ni_cw_data);
         model_cnt = model_cnt + 1;
      end
      last_accept = in_valid && in_ready;
      if (last_accept) begin
         raw = ref_encode(in_data[3:0]);
         e.clean = raw;
         e.nib   = in_data[3:0];
         e.inj   = inject_en && (inject_pos != 3'd0);
         e.cw    = e.inj ? (raw ^ (7'd1 << (inject_pos - 3'd1))) : raw;
         exp_q.push_back(e);
         e.clean = ref_encode(in_data[7:4]);
         e.cw    = e.clean;
         e.nib   = in_data[7:4];
         e.inj   = 1'b0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   logic [7:0] bytes3[3];
   logic [7:0] bytes9[9];
   logic [4:0] dec_v;
   int         idx;

   initial begin
      checks = 0; errors = 0; model_cnt = 0;
      hold_prev = 1'b0; prev_data = '0; last_accept = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      inject_en = 1'b0; inject_pos = '0; cw_ready = 1'b0;

      // Reset state
      #12;
      check("rst_cw_valid", cw_valid, 0);
      check("rst_cw_data", cw_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_cw_count", cw_count, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      cycle();

      // 1: single byte, ready high
      hs_log.delete(); ni_log.delete();
      in_valid = 1'b1; in_data = 8'hA5; cw_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      check("t1_size", hs_log.size(), 2);
      if (hs_log.size() == 2) begin
         check("t1_lo", hs_log[0], 7'h2D);
         check("t1_hi", hs_log[1], 7'h52);
      end
      check("t1_count", cw_count, 2);

      // 2: back-to-back bytes, no bubble
      hs_log.delete(); ni_log.delete();
      bytes3 = '{8'h00, 8'hFF, 8'hF0};
      idx = 0;
      for (int c = 0; c < 7; c++) begin
         in_valid = (idx < 3);
         in_data  = (idx < 3) ? bytes3[idx] : 8'h00;
         cycle();
         if (last_accept) idx++;
      end
      in_valid = 1'b0;
      check("t2_accepted", idx, 3);
      check("t2_size", hs_log.size(), 6);
      if (hs_log.size() == 6) begin
         check("t2_cw0", hs_log[0], 7'h00);
         check("t2_cw1", hs_log[1], 7'h00);
         check("t2_cw2", hs_log[2], 7'h7F);
         check("t2_cw3", hs_log[3], 7'h7F);
         check("t2_cw4", hs_log[4], 7'h00);
         check("t2_cw5", hs_log[5], 7'h7F);
      end
      cycle();

      // 3: downstream stalls of 3 cycles on each codeword
      hs_log.delete(); ni_log.delete();
      in_valid = 1'b1; in_data = 8'hA5; cw_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      check("t3_lo_held", cw_data, 7'h2D);
      cw_ready = 1'b1; cycle();
      cw_ready = 1'b0;
      repeat (3) cycle();
      check("t3_hi_held", cw_data, 7'h52);
      cw_ready = 1'b1; cycle();
      cycle();
      check("t3_size", hs_log.size(), 2);
      if (hs_log.size() == 2) begin
         check("t3_lo", hs_log[0], 7'h2D);
         check("t3_hi", hs_log[1], 7'h52);
      end

      // 4: error injection on the low codeword only
      hs_log.delete(); ni_log.delete();
      in_valid = 1'b1; in_data = 8'hA5; inject_en = 1'b1; inject_pos = 3'd3;
      cycle();
      in_valid = 1'b0; inject_en = 1'b0; inject_pos = 3'd0;
      repeat (3) cycle();
      check("t4_size", hs_log.size(), 2);
      if (hs_log.size() == 2) begin
         check("t4_lo", hs_log[0], 7'h29);
         check("t4_hi", hs_log[1], 7'h52);
         check("t4_ni_lo", ni_log[0], 7'h2D);
         dec_v = ref_decode(hs_log[0]);
         check("t4_corrected", dec_v[4], 1);
         check("t4_nibble", dec_v[3:0], 4'h5);
      end

      // 5: asynchronous reset during SEND_LO
      in_valid = 1'b1; in_data = 8'h3C; cw_ready = 1'b0;
      cycle();
      in_valid = 1'b0;
      check("t5_pre_valid", cw_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", cw_valid, 0);
      check("t5_rst_ready", in_ready, 1);
      check("t5_rst_count", cw_count, 0);
      exp_q.delete(); model_cnt = 0; hold_prev = 1'b0;
      #1 rst_n = 1'b1;
      cw_ready = 1'b1;
      repeat (4) cycle();

      // 6: nine bytes covering all 16 nibbles, counter wrap on CNT_W=4
      for (int n = 0; n < 8; n++) bytes9[n] = {4'(2 * n + 1), 4'(2 * n)};
      bytes9[8] = 8'h96;
      idx = 0;
      for (int c = 0; c < 24; c++) begin
         in_valid = (idx < 9);
         in_data  = (idx < 9) ? bytes9[idx] : 8'h00;
         cycle();
         if (last_accept) idx++;
      end
      in_valid = 1'b0;
      check("t6_accepted", idx, 9);
      check("t6_count16", cw_count, 18);
      check("t6_count4", c4_cw_count, 2);

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 600; c++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         in_data    = 8'($urandom);
         cw_ready   = ($urandom_range(0, 3) != 0);
         inject_en  = ($urandom_range(0, 2) == 0);
         inject_pos = 3'($urandom_range(0, 7));
         cycle();
      end
      in_valid = 1'b0; inject_en = 1'b0; cw_ready = 1'b1;
      repeat (4) cycle();
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
